// File: rtl/rv_iommu_fq_arbiter.sv
// Round-robin arbiter that funnels N fault-record producers into one registered
// fault-queue output stage; records granted while the FQ is off are dropped and counted.
module rv_iommu_fq_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_SRC-1:0]         src_valid_i,
    input  logic [N_SRC*256-1:0]     src_record_i,
    output logic [N_SRC-1:0]         src_ready_o,
    input  logic                     fq_en_i,
    output logic                     fq_valid_o,
    output logic [255:0]             fq_record_o,
    input  logic                     fq_ready_i,
    input  logic                     drop_clr_i,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     busy_o
);

    localparam int unsigned REC_W = 256;
    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

    stage_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [REC_W-1:0]   rec_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               stage_free;
    logic               grant_en;
    logic               out_hs;
    logic               flush;
    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;
    logic [1:0]         n_drop;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [REC_W-1:0]   rec_arr [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign rec_arr[g] = src_record_i[g*REC_W +: REC_W];
    end

    assign out_hs     = (state_q == FULL) && fq_ready_i;
    assign stage_free = (state_q == EMPTY) || fq_ready_i;
    assign grant_en   = stage_free || !fq_en_i;
    // A held record is flushed only if the writer did not take it this cycle.
    assign flush      = (state_q == FULL) && !fq_ready_i && !fq_en_i;

    // First valid source at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned off = 0; off < N_SRC; off++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
            if (scan_sum >= (PTR_W+1)'(N_SRC)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_SRC);
            end
            scan_idx = PTR_W'(scan_sum);
            if (grant_en && !gnt_any && src_valid_i[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        src_ready_o = '0;
        if (gnt_any) begin
            src_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign ptr_nxt = (gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // Clear takes effect first, then this cycle's drops are added with saturation.
    assign n_drop   = {1'b0, gnt_any && !fq_en_i} + {1'b0, flush};
    assign cnt_base = drop_clr_i ? '0 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(n_drop);
    assign cnt_nxt  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            rec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if (gnt_any) begin
                ptr_q <= ptr_nxt;
            end
            if (gnt_any && fq_en_i) begin
                state_q <= FULL;
                rec_q   <= rec_arr[gnt_idx];
            end else if (out_hs || flush) begin
                state_q <= EMPTY;
            end
        end
    end

    assign fq_valid_o  = (state_q == FULL);
    assign fq_record_o = rec_q;
    assign drop_cnt_o  = cnt_q;
    assign busy_o      = (state_q == FULL) || (|src_valid_i);

endmodule

// File: tb/tb_rv_iommu_fq_arbiter.sv
// Scoreboard bench for rv_iommu_fq_arbiter: directed producer traffic, expected
// output records queued at stimulus time and checked by an output monitor.
module tb_rv_iommu_fq_arbiter;

    localparam int N = 4;
    localparam int CW = 4;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       src_valid;
    logic [N*256-1:0]   src_record;
    logic [N-1:0]       src_ready;
    logic               fq_en;
    logic               fq_valid;
    logic [255:0]       fq_record;
    logic               fq_ready;
    logic               drop_clr;
    logic [CW-1:0]      drop_cnt;
    logic               busy;

    logic [255:0] src_q [N][$];
    logic [255:0] exp_q [$];
    logic [255:0] mon_exp;
    logic [255:0] held;
    logic         held_v;
    int errors;
    int checks;

    rv_iommu_fq_arbiter #(.N_SRC(N), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .src_valid_i  (src_valid),
        .src_record_i (src_record),
        .src_ready_o  (src_ready),
        .fq_en_i      (fq_en),
        .fq_valid_o   (fq_valid),
        .fq_record_o  (fq_record),
        .fq_ready_i   (fq_ready),
        .drop_clr_i   (drop_clr),
        .drop_cnt_o   (drop_cnt),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input int s, input int k);
        logic [7:0] b;
        b = 8'(s * 17 + k * 3 + 1);
        return {8'(s), 16'(k), {29{b}}};
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = (src_q[i].size() > 0);
            src_record[i*256 +: 256] = (src_q[i].size() > 0) ? src_q[i][0] : 256'd0;
        end
    endtask

    // One clock: producers see the grant at the edge and advance to their next record.
    task automatic step();
        logic [N-1:0] take;
        @(negedge clk);
        take = src_ready & src_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (take[i]) void'(src_q[i].pop_front());
        end
        drive();
        #1;
    endtask

    // Output monitor: every handshake must match the scoreboard head; held records must stay stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v <= 1'b0;
        end else begin
            if (fq_valid && held_v) begin
                chk("stable", fq_record, held);
            end
            if (fq_valid && fq_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %0h expected no record", fq_record);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("out_record", fq_record, mon_exp);
                end
            end
            held_v <= fq_valid && !fq_ready;
            held   <= fq_record;
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        src_valid = '0;
        src_record = '0;
        fq_en = 1'b1;
        fq_ready = 1'b1;
        drop_clr = 1'b0;
        held_v = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 256'(fq_valid), 256'd0);
        chk("rst_record", fq_record, 256'd0);
        chk("rst_drop", 256'(drop_cnt), 256'd0);
        chk("rst_ready", 256'(src_ready), 256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All sources valid: round-robin 0,1,2,3,0,... one record per cycle
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < N; s++) begin
                src_q[s].push_back(mk(s, k));
                exp_q.push_back(mk(s, k));
            end
        end
        drive();
        #1;
        chk("t1_ready0", 256'(src_ready), 256'b0001);
        chk("t1_valid0", 256'(fq_valid), 256'd0);
        step();
        chk("t1_latency", 256'(fq_valid), 256'd1);
        chk("t1_first", fq_record, mk(0, 0));
        chk("t1_ready1", 256'(src_ready), 256'b0010);
        for (int i = 0; i < 7; i++) step();
        chk("t1_valid8", 256'(fq_valid), 256'd1);
        step();
        chk("t1_drained", 256'(exp_q.size()), 256'd0);
        chk("t1_valid9", 256'(fq_valid), 256'd0);
        chk("t1_busy", 256'(busy), 256'd0);

        // Back-pressure: src1 held in stage, src3 granted in the release cycle
        fq_ready = 1'b0;
        src_q[1].push_back(mk(1, 5));
        src_q[3].push_back(mk(3, 5));
        exp_q.push_back(mk(1, 5));
        exp_q.push_back(mk(3, 5));
        drive();
        #1;
        chk("t2_ready_src1", 256'(src_ready), 256'b0010);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_ready", 256'(src_ready), 256'd0);
            chk("t2_hold_valid", 256'(fq_valid), 256'd1);
            chk("t2_hold_rec", fq_record, mk(1, 5));
            step();
        end
        chk("t2_busy", 256'(busy), 256'd1);
        fq_ready = 1'b1;
        #1;
        chk("t2_ready_src3", 256'(src_ready), 256'b1000);
        step();
        chk("t2_next_rec", fq_record, mk(3, 5));
        step();
        chk("t2_empty", 256'(fq_valid), 256'd0);

        // FQ disabled: ten src2 records consumed one per cycle and dropped
        fq_en = 1'b0;
        for (int k = 0; k < 10; k++) src_q[2].push_back(mk(2, 10 + k));
        drive();
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_ready", 256'(src_ready), 256'b0100);
            step();
        end
        chk("t3_valid", 256'(fq_valid), 256'd0);
        chk("t3_drop", 256'(drop_cnt), 256'd10);

        // Clear with no drops, then flush of a held record plus a dropped grant
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("t4_clr", 256'(drop_cnt), 256'd0);
        fq_en = 1'b1;
        fq_ready = 1'b0;
        src_q[0].push_back(mk(0, 20));
        src_q[0].push_back(mk(0, 21));
        drive();
        #1;
        step();
        chk("t4_full", 256'(fq_valid), 256'd1);
        chk("t4_full_rec", fq_record, mk(0, 20));
        fq_en = 1'b0;
        #1;
        chk("t4_ready", 256'(src_ready), 256'b0001);
        step();
        chk("t4_flushed", 256'(fq_valid), 256'd0);
        chk("t4_drop2", 256'(drop_cnt), 256'd2);

        // Saturation at 15, then clear together with one drop
        for (int k = 0; k < 20; k++) src_q[1].push_back(mk(1, 30 + k));
        drive();
        #1;
        for (int i = 0; i < 12; i++) step();
        chk("t5_drop14", 256'(drop_cnt), 256'd14);
        step();
        chk("t5_drop15", 256'(drop_cnt), 256'd15);
        for (int i = 0; i < 7; i++) step();
        chk("t5_sat", 256'(drop_cnt), 256'd15);
        src_q[1].push_back(mk(1, 60));
        drop_clr = 1'b1;
        drive();
        #1;
        step();
        drop_clr = 1'b0;
        chk("t5_clr_drop", 256'(drop_cnt), 256'd1);

        // Async reset while FULL and granting
        fq_en = 1'b1;
        fq_ready = 1'b0;
        src_q[2].push_back(mk(2, 70));
        drive();
        #1;
        step();
        chk("t6_full", 256'(fq_valid), 256'd1);
        fq_ready = 1'b1;
        src_q[0].push_back(mk(0, 71));
        src_q[3].push_back(mk(3, 71));
        drive();
        #1;
        chk("t6_ready_pre", 256'(src_ready), 256'b1000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 256'(fq_valid), 256'd0);
        chk("t6_rst_rec", fq_record, 256'd0);
        chk("t6_rst_drop", 256'(drop_cnt), 256'd0);
        chk("t6_rst_ready", 256'(src_ready), 256'b0001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 71));
        exp_q.push_back(mk(3, 71));
        #1;
        chk("t6_ready_post", 256'(src_ready), 256'b0001);
        step();
        chk("t6_first_rec", fq_record, mk(0, 71));
        step();
        step();
        chk("t6_drained", 256'(exp_q.size()), 256'd0);
        chk("t6_idle", 256'(fq_valid), 256'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
